// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target with a small register bank
// Filtered SCL/SDA feed one bus FSM; SDA is only ever pulled low, and only after SCL falls.
module i2c_target_regs #(
   parameter logic [6:0] DEV_ADDR = 7'h42,
   parameter int         NREG     = 4,
   parameter int         FILT     = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      scl_in,
   input  logic                      sda_in,
   output logic                      sda_oe,
   output logic [8*NREG-1:0]         regs_flat,
   output logic                      wr_pulse,
   output logic [$clog2(NREG)-1:0]   wr_idx,
   output logic [7:0]                wr_data,
   output logic                      busy
);
   localparam int IW = $clog2(NREG);
   localparam int CW = $clog2(FILT + 1);
   localparam logic [CW-1:0] FMAX = CW'(FILT - 1);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
   } state_t;

   // index 0 = SCL, index 1 = SDA; everything resets to the idle-high bus level
   logic [1:0]    r_s1, r_s2, r_filt, r_fprev;
   logic [CW-1:0] r_fcnt [2];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1     <= 2'b11;
         r_s2     <= 2'b11;
         r_filt   <= 2'b11;
         r_fprev  <= 2'b11;
         r_fcnt[0] <= '0;
         r_fcnt[1] <= '0;
      end else begin
         r_s1    <= {sda_in, scl_in};
         r_s2    <= r_s1;
         r_fprev <= r_filt;
         for (int i = 0; i < 2; i++) begin
            if (r_s2[i] == r_filt[i]) begin
               r_fcnt[i] <= '0;
            end else if (r_fcnt[i] == FMAX) begin
               r_filt[i] <= r_s2[i];
               r_fcnt[i] <= '0;
            end else begin
               r_fcnt[i] <= r_fcnt[i] + 1'b1;
            end
         end
      end
   end

   logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
   assign w_scl      = r_filt[0];
   assign w_sda      = r_filt[1];
   assign w_scl_rise = w_scl & ~r_fprev[0];
   assign w_scl_fall = ~w_scl & r_fprev[0];
   assign w_start    = w_scl & r_fprev[0] & r_fprev[1] & ~w_sda;
   assign w_stop     = w_scl & r_fprev[0] & ~r_fprev[1] & w_sda;

   state_t        r_state;
   logic [3:0]    r_bitcnt;
   logic [6:0]    r_shift;
   logic          r_rw, r_oe, r_busy, r_wr_pulse;
   logic [IW-1:0] r_ptr, r_wr_idx;
   logic [7:0]    r_wr_data;
   logic [7:0]    r_regs [NREG];

   logic [7:0]    w_byte, w_rd_byte;
   logic [IW-1:0] w_next_ptr;
   assign w_byte     = {r_shift, w_sda};
   assign w_rd_byte  = r_regs[r_ptr];
   assign w_next_ptr = r_ptr + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_bitcnt   <= '0;
         r_shift    <= '0;
         r_rw       <= 1'b0;
         r_oe       <= 1'b0;
         r_busy     <= 1'b0;
         r_wr_pulse <= 1'b0;
         r_ptr      <= '0;
         r_wr_idx   <= '0;
         r_wr_data  <= '0;
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else begin
         r_wr_pulse <= 1'b0;
         if (w_stop) begin
            r_state <= IDLE;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
         end else if (w_start) begin
            r_state  <= ADDR;
            r_oe     <= 1'b0;
            r_busy   <= 1'b1;
            r_bitcnt <= '0;
         end else begin
            case (r_state)
               ADDR, PTR, WDATA: if (w_scl_rise) begin
                  r_shift  <= {r_shift[5:0], w_sda};
                  r_bitcnt <= r_bitcnt + 1'b1;
                  if (r_bitcnt == 4'd7) begin
                     if (r_state == ADDR) begin
                        r_rw <= w_sda;
                        if (r_shift == DEV_ADDR) begin
                           r_state <= ADDR_ACK;
                        end else begin
                           r_state <= IDLE;
                           r_busy  <= 1'b0;
                        end
                     end else if (r_state == PTR) begin
                        r_ptr   <= w_byte[IW-1:0];
                        r_state <= PTR_ACK;
                     end else begin
                        r_regs[r_ptr] <= w_byte;
                        r_wr_pulse    <= 1'b1;
                        r_wr_idx      <= r_ptr;
                        r_wr_data     <= w_byte;
                        r_ptr         <= w_next_ptr;
                        r_state       <= WDATA_ACK;
                     end
                  end
               end
               // first fall pulls the ACK low, the second fall ends the slot
               ADDR_ACK, PTR_ACK, WDATA_ACK: if (w_scl_fall) begin
                  if (!r_oe) begin
                     r_oe <= 1'b1;
                  end else begin
                     r_bitcnt <= '0;
                     if (r_state == ADDR_ACK && r_rw) begin
                        r_shift <= w_rd_byte[6:0];
                        r_oe    <= ~w_rd_byte[7];
                        r_state <= RDATA;
                     end else begin
                        r_oe    <= 1'b0;
                        r_state <= (r_state == ADDR_ACK) ? PTR : WDATA;
                     end
                  end
               end
               RDATA: begin
                  if (w_scl_rise) begin
                     r_bitcnt <= r_bitcnt + 1'b1;
                  end else if (w_scl_fall) begin
                     if (r_bitcnt == 4'd8) begin
                        r_oe     <= 1'b0;
                        r_bitcnt <= '0;
                        r_state  <= RDATA_ACK;
                     end else begin
                        r_oe    <= ~r_shift[6];
                        r_shift <= {r_shift[5:0], 1'b0};
                     end
                  end
               end
               // r_bitcnt == 1 marks "controller ACKed, next byte goes out on the fall"
               RDATA_ACK: begin
                  if (w_scl_rise) begin
                     if (!w_sda) begin
                        r_ptr    <= w_next_ptr;
                        r_bitcnt <= 4'd1;
                     end else begin
                        r_oe    <= 1'b0;
                        r_state <= WAIT_STOP;
                     end
                  end else if (w_scl_fall && r_bitcnt == 4'd1) begin
                     r_shift  <= w_rd_byte[6:0];
                     r_oe     <= ~w_rd_byte[7];
                     r_bitcnt <= '0;
                     r_state  <= RDATA;
                  end
               end
               IDLE, WAIT_STOP: ;
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   for (genvar g = 0; g < NREG; g++) begin : g_flat
      assign regs_flat[8*g +: 8] = r_regs[g];
   end

   assign sda_oe   = r_oe;
   assign wr_pulse = r_wr_pulse;
   assign wr_idx   = r_wr_idx;
   assign wr_data  = r_wr_data;
   assign busy     = r_busy;
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - randomized bench for i2c_target_regs against a transaction-level model
module tb_i2c_target_regs;
   localparam int NREG = 4;
   localparam int Q    = 12;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        scl = 1'b1;
   logic        ctl_sda = 1'b1;
   logic        sda_bus;
   logic        sda_oe, wr_pulse, busy;
   logic [31:0] regs_flat;
   logic [1:0]  wr_idx;
   logic [7:0]  wr_data;

   i2c_target_regs #(.DEV_ADDR(7'h42), .NREG(NREG), .FILT(3)) dut (
      .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda_bus), .sda_oe(sda_oe),
      .regs_flat(regs_flat), .wr_pulse(wr_pulse), .wr_idx(wr_idx),
      .wr_data(wr_data), .busy(busy)
   );

   always #5 clk = ~clk;
   assign sda_bus = ctl_sda & ~sda_oe;

   int         checks = 0, errors = 0;
   logic [7:0] m_regs [NREG];
   int         m_ptr = 0;
   int         q_idx[$];
   logic [7:0] q_dat[$];
   int         log_idx[$];
   logic [7:0] log_dat[$];
   logic [7:0] rd_log[$];
   bit         oe_seen = 0, glitch_en = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_flat();
      logic [31:0] f;
      for (int i = 0; i < NREG; i++) f[8*i +: 8] = m_regs[i];
      return f;
   endfunction

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (sda_oe) oe_seen = 1;
         if (wr_pulse) begin
            if (q_idx.size() == 0) chk("unexpected_wr_pulse", 32'd1, 32'd0);
            else begin
               chk("wr_idx", wr_idx, q_idx.pop_front());
               chk("wr_data", wr_data, q_dat.pop_front());
            end
            log_idx.push_back(wr_idx);
            log_dat.push_back(wr_data);
         end
         if (q_idx.size() == 0) chk("regs_flat", regs_flat, model_flat());
      end
   end

   task automatic wclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_bit(input logic b, output logic r);
      ctl_sda = b; wclk(Q);
      scl = 1'b1; wclk(Q);
      r = sda_bus;
      if (glitch_en) begin ctl_sda = ~b; wclk(1); ctl_sda = b; end
      wclk(Q);
      scl = 1'b0; wclk(Q);
   endtask

   task automatic bus_start();
      ctl_sda = 1'b1; wclk(Q);
      scl = 1'b1; wclk(Q);
      ctl_sda = 1'b0; wclk(Q);
      scl = 1'b0; wclk(Q);
   endtask

   task automatic bus_stop();
      ctl_sda = 1'b0; wclk(Q);
      scl = 1'b1; wclk(Q);
      ctl_sda = 1'b1; wclk(2*Q);
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
      bus_bit(1'b1, ack);
   endtask

   task automatic recv_byte(input logic nack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) begin bus_bit(1'b1, r); d[i] = r; end
      bus_bit(nack, r);
   endtask

   task automatic tx_ptr(input logic [7:0] p);
      logic a;
      bus_start();
      send_byte(8'h84, a); chk("ack_addr_w", a, 0);
      m_ptr = p % NREG;
      send_byte(p, a); chk("ack_ptr", a, 0);
   endtask

   task automatic tx_data(input logic [7:0] d);
      logic a;
      q_idx.push_back(m_ptr); q_dat.push_back(d);
      m_regs[m_ptr] = d;
      m_ptr = (m_ptr + 1) % NREG;
      send_byte(d, a); chk("ack_data", a, 0);
   endtask

   task automatic tx_read(input int n);
      logic a;
      logic [7:0] d;
      bus_start();
      send_byte(8'h85, a); chk("ack_addr_r", a, 0);
      for (int k = 0; k < n; k++) begin
         recv_byte(k == n - 1, d);
         chk("rd_data", d, m_regs[m_ptr]);
         rd_log.push_back(d);
         if (k != n - 1) m_ptr = (m_ptr + 1) % NREG;
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic       a, r;
      logic [6:0] ad;
      int         n;
      for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
      wclk(4);
      chk("rst_sda_oe", sda_oe, 0); chk("rst_regs", regs_flat, 0);
      chk("rst_wr_pulse", wr_pulse, 0); chk("rst_wr_idx", wr_idx, 0);
      chk("rst_wr_data", wr_data, 0); chk("rst_busy", busy, 0);
      rst = 1'b1; wclk(20);

      tx_ptr(8'h01);
      chk("busy_in_xfer", busy, 1);
      tx_data(8'hA5); bus_stop();
      chk("busy_after_stop", busy, 0);
      chk("t1_log_n", log_idx.size(), 1);
      chk("t1_idx", log_idx[0], 1); chk("t1_data", log_dat[0], 8'hA5);
      chk("t1_reg1", regs_flat[15:8], 8'hA5);

      tx_ptr(8'h03); tx_data(8'h11); tx_data(8'h22); bus_stop();
      chk("t2_idx_a", log_idx[1], 3); chk("t2_data_a", log_dat[1], 8'h11);
      chk("t2_idx_b", log_idx[2], 0); chk("t2_data_b", log_dat[2], 8'h22);
      chk("t2_regs", regs_flat, 32'h1100_A522);

      tx_ptr(8'h02); tx_data(8'h5C); bus_stop();
      tx_ptr(8'h02); bus_stop();
      tx_read(2);
      chk("t3_oe_after_nack", sda_oe, 0);
      bus_stop();
      chk("t3_busy", busy, 0);
      chk("t3_rd0", rd_log[0], 8'h5C); chk("t3_rd1", rd_log[1], 8'h11);

      bus_start(); oe_seen = 0;
      send_byte(8'h90, a);
      chk("t4_nack", a, 1); chk("t4_oe_never", oe_seen, 0); chk("t4_busy", busy, 0);
      bus_stop();

      tx_ptr(8'h00);
      for (int i = 0; i < 4; i++) bus_bit(i[0], r);
      tx_read(1); bus_stop();
      chk("t5_rd", rd_log[rd_log.size()-1], 8'h22);
      chk("t5_no_write", log_idx.size(), 4);

      bus_start();
      for (int i = 7; i >= 0; i--) bus_bit(i == 2 || i == 7 ? 1'b1 : 1'b0, r);
      ctl_sda = 1'b1;
      chk("t6_oe_in_ack", sda_oe, 1);
      @(posedge clk); #2 rst = 1'b0;
      #1 chk("t6_oe_async", sda_oe, 0);
      chk("t6_regs_clr", regs_flat, 0); chk("t6_busy_clr", busy, 0);
      for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
      m_ptr = 0; q_idx.delete(); q_dat.delete();
      scl = 1'b1; ctl_sda = 1'b1; wclk(5);
      rst = 1'b1; wclk(20);
      tx_ptr(8'h00); tx_data(8'h3C); tx_data(8'hC3); bus_stop();
      chk("t6_regs_after", regs_flat, 32'h0000_C33C);

      @(negedge clk) ctl_sda = 1'b0;
      @(negedge clk) ctl_sda = 1'b1;
      wclk(20);
      chk("t7_no_start", busy, 0);
      glitch_en = 1;
      tx_ptr(8'h01); tx_data(8'h96); tx_data(8'h0F); bus_stop();
      glitch_en = 0;
      chk("t7_regs", regs_flat[23:8], 16'h0F96);

      for (int it = 0; it < 14; it++) begin
         case ($urandom_range(0, 2))
            0: begin
               tx_ptr(8'($urandom_range(0, 255)));
               n = $urandom_range(1, 3);
               for (int k = 0; k < n; k++) tx_data(8'($urandom));
               bus_stop();
            end
            1: begin
               tx_ptr(8'($urandom_range(0, 255)));
               tx_read($urandom_range(1, 3));
               bus_stop();
            end
            default: begin
               ad = 7'($urandom_range(0, 127));
               if (ad == 7'h42) ad = 7'h43;
               bus_start(); oe_seen = 0;
               send_byte({ad, 1'($urandom)}, a);
               chk("rand_bad_nack", a, 1); chk("rand_bad_oe", oe_seen, 0);
               chk("rand_bad_busy", busy, 0);
               bus_stop();
            end
         endcase
         chk("rand_busy_idle", busy, 0);
      end

      wclk(10);
      chk("pending_writes", q_idx.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
